// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - flit-type codes, field layout and FSM states shared by the PE injection path
package noc_flit_pkg;

  localparam int FLIT_W_DEF = 20;
  // The type field occupies the top FT_W bits of every flit.
  localparam int FT_W = 2;

  localparam logic [FT_W-1:0] FT_HEAD   = 2'b10;
  localparam logic [FT_W-1:0] FT_BODY   = 2'b00;
  localparam logic [FT_W-1:0] FT_TAIL   = 2'b01;
  localparam logic [FT_W-1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic ft_opens(input logic [FT_W-1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

  function automatic logic ft_closes(input logic [FT_W-1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_SINGLE);
  endfunction

  function automatic logic ft_is_cont(input logic [FT_W-1:0] ft);
    return (ft == FT_BODY) || (ft == FT_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter; search begins at ptr and wraps
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic          found;
  logic [PW-1:0] idx;
  int            pos;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pe_inject_scheduler.sv
// rtl/pe_inject_scheduler.sv - shares one router injection port among PE flit sources
// Round-robin packet arbitration, wormhole ownership head-to-tail, credit-gated transfers.
module pe_inject_scheduler
  import noc_flit_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int FLIT_W  = FLIT_W_DEF,
  parameter int CREDITS = 7,
  parameter int CNT_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*FLIT_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      ci,
  output logic [FLIT_W-1:0]         dataout,
  output logic                      out_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic [CNT_W-1:0]          credit_cnt,
  output logic                      err
);

  localparam int PW = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_e              state_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [NUM_SRC-1:0]  grant_q;
  logic [FLIT_W-1:0]   dataout_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    credit_q, credit_d;
  logic                err_q, err_d;
  logic                head_sent_q;

  logic [NUM_SRC-1:0]  head_req, arb_gnt;
  logic                arb_any;
  logic                idle_cont;
  logic [FLIT_W-1:0]   own_flit;
  logic [PW-1:0]       own_idx, rr_next;
  logic [FT_W-1:0]     own_ft;
  logic                xfer;

  always_comb begin
    head_req  = '0;
    idle_cont = 1'b0;
    own_flit  = '0;
    own_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      head_req[i] = src_valid[i] && ft_opens(src_data[i*FLIT_W + FLIT_W - FT_W +: FT_W]);
      idle_cont   = idle_cont || (src_valid[i] && ft_is_cont(src_data[i*FLIT_W + FLIT_W - FT_W +: FT_W]));
      if (grant_q[i]) begin
        own_flit = src_data[i*FLIT_W +: FLIT_W];
        own_idx  = PW'(i);
      end
    end
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req (head_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  assign own_ft    = own_flit[FLIT_W-1 -: FT_W];
  assign src_ready = (state_q == S_BUSY && credit_q != '0) ? grant_q : '0;
  assign xfer      = |(src_valid & src_ready);
  assign rr_next   = (own_idx == PW'(NUM_SRC-1)) ? '0 : own_idx + 1'b1;

  // A credit return that coincides with a transfer cancels out; a return into a full counter is an overflow.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (xfer && !ci) begin
      credit_d = credit_q - 1'b1;
    end else if (ci && !xfer) begin
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else                      credit_d = credit_q + 1'b1;
    end
    if (state_q == S_IDLE && idle_cont) err_d = 1'b1;
    if (xfer && head_sent_q && ft_opens(own_ft)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
      credit_q    <= CRED_MAX;
      err_q       <= 1'b0;
      head_sent_q <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      err_q       <= err_d;
      out_valid_q <= xfer;
      if (xfer) dataout_q <= own_flit;
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_q     <= arb_gnt;
            head_sent_q <= 1'b0;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (xfer) begin
            head_sent_q <= 1'b1;
            if (ft_closes(own_ft)) begin
              state_q  <= S_IDLE;
              grant_q  <= '0;
              rr_ptr_q <= rr_next;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dataout    = dataout_q;
  assign out_valid  = out_valid_q;
  assign grant      = grant_q;
  assign credit_cnt = credit_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// tb/tb_pe_inject_scheduler.sv - scoreboard bench for pe_inject_scheduler with a packet-level reference model
module tb_pe_inject_scheduler;

  localparam int NS = 4;
  localparam int FW = 20;
  localparam int CR = 7;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid;
  logic [NS*FW-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic             ci;
  logic [FW-1:0]    dataout;
  logic             out_valid;
  logic [NS-1:0]    grant;
  logic [CW-1:0]    credit_cnt;
  logic             err;

  always #5 clk = ~clk;

  pe_inject_scheduler #(.NUM_SRC(NS), .FLIT_W(FW), .CREDITS(CR), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .ci         (ci),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .grant      (grant),
    .credit_cnt (credit_cnt),
    .err        (err)
  );

  logic [FW-1:0] srcq [NS][$];
  logic [FW-1:0] mq   [NS][$];
  logic [FW-1:0] expq [$];
  logic [FW-1:0] drv_f;
  bit started [NS];
  bit acc     [NS];
  int n_cmp = 0, n_bad = 0;
  int flits_seen = 0, ci_issued = 0, mdl_ptr = 0, ci_mode = 0, ci_pct = 100, min_credit = CR;
  bit ci_man = 1'b0, bubble_en = 1'b0, chk_credit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkflit(input logic [1:0] ft, input int s);
    return {ft, 2'(s), 16'($urandom)};
  endfunction

  task automatic load(input int s, input logic [FW-1:0] f);
    srcq[s].push_back(f);
    mq[s].push_back(f);
  endtask

  task automatic add_pkt(input int s, input int len);
    if (len == 1) begin
      load(s, mkflit(2'b11, s));
    end else begin
      load(s, mkflit(2'b10, s));
      for (int i = 0; i < len - 2; i++) load(s, mkflit(2'b00, s));
      load(s, mkflit(2'b01, s));
    end
  endtask

  // Packet-granular round robin over everything loaded: serve the next non-empty source from the pointer.
  task automatic model_run();
    bit served;
    logic [FW-1:0] f;
    do begin
      served = 1'b0;
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (mdl_ptr + k) % NS;
        if (mq[s].size() != 0) begin
          do begin
            f = mq[s].pop_front();
            expq.push_back(f);
          end while (f[FW-2] == 1'b0 && mq[s].size() != 0);
          mdl_ptr = (s + 1) % NS;
          served  = 1'b1;
          break;
        end
      end
    end while (served);
  endtask

  function automatic bit srcs_empty();
    for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || !srcs_empty()) && n < budget) begin
      cycles(1);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d flits outstanding, required 0", expq.size());
      expq.delete();
      for (int s = 0; s < NS; s++) srcq[s].delete();
    end
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((flits_seen != ci_issued || ci !== 1'b0) && n < budget) begin
      cycles(1);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL settle_timeout: occupancy %0d, required 0", flits_seen - ci_issued);
    end
  endtask

  // Source and router-credit driver.
  initial begin
    src_valid = '0;
    src_data  = '0;
    ci        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        if (acc[s] && srcq[s].size() != 0) begin
          drv_f = srcq[s].pop_front();
          started[s] = (drv_f[FW-2] == 1'b0);
        end
        if (srcq[s].size() != 0 && (!started[s] || !bubble_en || $urandom_range(0, 3) != 0)) begin
          src_valid[s] = 1'b1;
          src_data[s*FW +: FW] = srcq[s][0];
        end else begin
          src_valid[s] = 1'b0;
        end
      end
      if (ci_mode == 0) ci = ci_man;
      else ci = (flits_seen > ci_issued) && ($urandom_range(0, 99) < ci_pct);
      if (ci) ci_issued++;
    end
  end

  // Monitor: scoreboard pop on every emitted flit plus per-cycle invariants.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        flits_seen++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_flit: got %0h, required no flit", dataout);
        end else begin
          chk("dataout", dataout, expq.pop_front());
        end
      end
      chk("ready_within_grant", src_ready & ~grant, 0);
      chk("grant_onehot0", $countones(grant) <= 1, 1);
      if (chk_credit) begin
        chk("credit_cnt", credit_cnt, CR - flits_seen + ci_issued - int'(ci));
        if (int'(credit_cnt) < min_credit) min_credit = int'(credit_cnt);
      end
      for (int s = 0; s < NS; s++) acc[s] = src_valid[s] && src_ready[s] && !rst;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1); add_pkt(0, 1);
    model_run();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_credit", credit_cnt, CR);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_err", err, 0);

    rst = 1'b0;
    ci_mode = 2; ci_pct = 100; chk_credit = 1'b1; min_credit = CR;
    drain(200);
    settle(200);
    chk("rr_min_credit_ge6", min_credit >= 6, 1);

    bubble_en = 1'b1;
    add_pkt(1, 4); add_pkt(0, 1); add_pkt(2, 1);
    model_run();
    drain(300);
    settle(200);

    for (int b = 0; b < 15; b++) begin
      for (int s = 0; s < NS; s++) repeat ($urandom_range(0, 2)) add_pkt(s, $urandom_range(1, 5));
      ci_pct = $urandom_range(25, 90);
      model_run();
      drain(3000);
    end
    ci_pct = 100;
    settle(200);
    chk("refill_credit", credit_cnt, CR);
    chk("random_err", err, 0);

    bubble_en = 1'b0; ci_mode = 0; ci_man = 1'b0;
    add_pkt(0, 9);
    model_run();
    base = flits_seen;
    cycles(20);
    chk("stall_flits", flits_seen - base, 7);
    chk("stall_credit", credit_cnt, 0);
    chk("stall_ready", src_ready, 0);
    ci_man = 1'b1;
    cycles(1);
    ci_man = 1'b0;
    cycles(1);
    chk("pulse_credit_up", credit_cnt, 1);
    chk("pulse_no_flit_yet", out_valid, 0);
    cycles(1);
    chk("pulse_flit_out", out_valid, 1);
    chk("pulse_credit_down", credit_cnt, 0);
    chk("pulse_flit_count", flits_seen - base, 8);
    ci_mode = 2; ci_pct = 100;
    drain(200);
    settle(200);
    chk("after_stall_credit", credit_cnt, CR);

    ci_mode = 0; ci_man = 1'b0;
    add_pkt(2, 1);
    model_run();
    cycles(1);
    ci_man = 1'b1;
    cycles(1);
    ci_man = 1'b0;
    cycles(1);
    chk("simul_out_valid", out_valid, 1);
    chk("simul_credit", credit_cnt, CR);
    chk("simul_err", err, 0);
    chk_credit = 1'b0;
    ci_man = 1'b1;
    cycles(1);
    ci_man = 1'b0;
    cycles(1);
    chk("ovf_credit", credit_cnt, CR);
    chk("ovf_err", err, 1);

    ci_mode = 2; ci_pct = 100;
    load(3, mkflit(2'b10, 3));
    load(3, mkflit(2'b00, 3));
    model_run();
    drain(200);
    cycles(3);
    rst = 1'b1; ci_mode = 0; ci_man = 1'b0; started[3] = 1'b0;
    cycles(1);
    rst = 1'b0;
    chk("midrst_grant", grant, 0);
    chk("midrst_credit", credit_cnt, CR);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_src_ready", src_ready, 0);
    mdl_ptr = 0; flits_seen = 0; ci_issued = 0; chk_credit = 1'b1;
    add_pkt(3, 1); add_pkt(0, 1);
    model_run();
    ci_mode = 2;
    drain(200);
    settle(200);
    chk("final_err", err, 0);
    chk("final_queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
